// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {instr, npc, PC} FIFO between fetch and decode, with one-cycle flush.
// Optional macro FETCHQ_BYPASS_EN adds a zero-latency empty-queue bypass. Revision: 1.0
`default_nettype none

module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] npc,
    input  logic [WORD_W-1:0] PC,
    input  logic              flush,
    input  logic              dec_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pcout,
    output logic              valid,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = 3 * WORD_W;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty_w;
    logic             full_w;
    logic             bypass_w;
    logic             push_ok;
    logic             pop_ok;
    logic [REC_W-1:0] in_rec_w;
    logic [REC_W-1:0] head_w;

    assign in_rec_w = {imemload, npc, PC};
    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CNT_W'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
    // Empty queue with a same-cycle consumer: hand the record straight through.
    assign bypass_w = empty_w && ihit && dec_ready && !flush;
`else
    assign bypass_w = 1'b0;
`endif

    assign pop_ok  = dec_ready && !empty_w && !flush;
    assign push_ok = ihit && (!full_w || pop_ok) && !flush && !bypass_w;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries survive a flush; only pointers and count are reset then.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= in_rec_w;
        end
    end

    always_comb begin
        head_w = '0;
        if (bypass_w)      head_w = in_rec_w;
        else if (!empty_w) head_w = mem_q[rd_ptr_q];
    end

    assign instr = head_w[3*WORD_W-1:2*WORD_W];
    assign pc    = head_w[2*WORD_W-1:WORD_W];
    assign pcout = head_w[WORD_W-1:0];
    assign valid = !empty_w || bypass_w;
    assign full  = full_w;
    assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors plus a queue scoreboard for fetch_queue (DEPTH = 4).
`default_nettype none

module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int WORD_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              CLK;
    logic              nRST;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] PC;
    logic              flush;
    logic              dec_ready;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pcout;
    logic              valid;
    logic              full;
    logic [CNT_W-1:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .npc(npc), .PC(PC),
        .flush(flush), .dec_ready(dec_ready), .instr(instr), .pc(pc), .pcout(pcout),
        .valid(valid), .full(full), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ih;
        logic [31:0] ins;
        logic        dr;
        logic        fl;
        int          e_cnt;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 26;
    vec_t        tbl [NV];
    logic [95:0] sbq [$];
    int          n_vec;
    int          n_bad;

    function automatic logic [31:0] pc_of(input logic [31:0] ins);
        return ((ins >> 4) - 32'd1) << 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle from the falling edge, check outputs, then advance the model at the rising edge.
    task automatic cycle(input logic ih, input logic [31:0] ins, input logic dr, input logic fl,
                         input bit use_exp, input int e_cnt, input logic e_valid,
                         input logic [31:0] e_instr);
        logic [95:0] rec;
        logic [95:0] head;
        logic        byp, m_valid, pop, push;
        rec       = {ins, pc_of(ins) + 32'd4, pc_of(ins)};
        ihit      = ih;
        imemload  = rec[95:64];
        npc       = rec[63:32];
        PC        = rec[31:0];
        dec_ready = dr;
        flush     = fl;
        #1;
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = (sbq.size() == 0) && ih && dr && !fl;
`endif
        m_valid = (sbq.size() != 0) || byp;
        head    = byp ? rec : ((sbq.size() != 0) ? sbq[0] : 96'd0);
        chk("sb_count", 32'(count), 32'(sbq.size()));
        chk("sb_full",  32'(full),  32'(sbq.size() == DEPTH));
        chk("sb_valid", 32'(valid), 32'(m_valid));
        chk("sb_instr", instr, head[95:64]);
        chk("sb_npc",   pc,    head[63:32]);
        chk("sb_pc",    pcout, head[31:0]);
        if (use_exp) begin
            chk("tbl_count", 32'(count), 32'(e_cnt));
            chk("tbl_valid", 32'(valid), 32'(e_valid));
            chk("tbl_instr", instr, e_instr);
        end
        pop  = dr && (sbq.size() != 0) && !fl;
        push = ih && ((sbq.size() < DEPTH) || pop) && !fl && !byp;
        @(posedge CLK);
        if (fl) begin
            sbq.delete();
        end else begin
            if (pop)  void'(sbq.pop_front());
            if (push) sbq.push_back(rec);
        end
        @(negedge CLK);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //          ih  ins      dr fl cnt v  instr
        tbl[0]  = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 32'h11, 1'b0, 1'b0, 0, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1, 1'b1, 32'h11};
        tbl[3]  = '{1'b1, 32'h33, 1'b0, 1'b0, 2, 1'b1, 32'h11};
        tbl[4]  = '{1'b1, 32'h44, 1'b0, 1'b0, 3, 1'b1, 32'h11};
        tbl[5]  = '{1'b1, 32'h55, 1'b0, 1'b0, 4, 1'b1, 32'h11};
        tbl[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 4, 1'b1, 32'h11};
        tbl[7]  = '{1'b1, 32'h55, 1'b1, 1'b0, 4, 1'b1, 32'h11};
        tbl[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 4, 1'b1, 32'h22};
        tbl[9]  = '{1'b1, 32'h66, 1'b0, 1'b0, 3, 1'b1, 32'h33};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 4, 1'b1, 32'h33};
        tbl[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 3, 1'b1, 32'h44};
        tbl[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 32'h55};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h66};
        tbl[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
        tbl[15] = '{1'b1, 32'h11, 1'b0, 1'b0, 0, 1'b0, 32'h00};
        tbl[16] = '{1'b1, 32'h22, 1'b0, 1'b0, 1, 1'b1, 32'h11};
        tbl[17] = '{1'b1, 32'h33, 1'b0, 1'b0, 2, 1'b1, 32'h11};
        tbl[18] = '{1'b1, 32'h77, 1'b1, 1'b1, 3, 1'b1, 32'h11};
        tbl[19] = '{1'b1, 32'h88, 1'b0, 1'b0, 0, 1'b0, 32'h00};
        tbl[20] = '{1'b0, 32'h00, 1'b0, 1'b0, 1, 1'b1, 32'h88};
        tbl[21] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h88};
        tbl[22] = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 1'b0, 32'h00};
`ifdef FETCHQ_BYPASS_EN
        tbl[23] = '{1'b1, 32'h99, 1'b1, 1'b0, 0, 1'b1, 32'h99};
        tbl[24] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
`else
        tbl[23] = '{1'b1, 32'h99, 1'b1, 1'b0, 0, 1'b0, 32'h00};
        tbl[24] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h99};
`endif
        tbl[25] = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 1'b0, 32'h00};

        nRST = 1'b0; ihit = 1'b0; imemload = '0; npc = '0; PC = '0;
        flush = 1'b0; dec_ready = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++)
            cycle(tbl[i].ih, tbl[i].ins, tbl[i].dr, tbl[i].fl, 1'b1,
                  tbl[i].e_cnt, tbl[i].e_valid, tbl[i].e_instr);

        // Asynchronous reset in the middle of a cycle, then push on the first edge after release.
        cycle(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);
        cycle(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);
        ihit = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_full",  32'(full),  32'd0);
        sbq.delete();
        @(negedge CLK);
        nRST = 1'b1;
        cycle(1'b1, 32'hC3, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h00);
        cycle(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 1'b1, 32'hC3);

        // Random traffic against the scoreboard.
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 1'b0, 0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between the fetch stage and the decode stage of the pipelined CPU. It generalises the single-entry IF/ID latch into a DEPTH-entry FIFO of {instruction, next-PC, fetch-PC} records. Fetch can keep running on instruction-cache hits while decode is stalled. A branch/jump flush discards every buffered record in one cycle. Decode sees the oldest record, or a zero bubble when the queue is empty.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- WORD_W, 32, width of instr, npc and PC fields
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  push request: fetch has a valid instruction this cycle
- imemload  in  WORD_W  fetched instruction
- npc  in  WORD_W  PC+4 of fetched instruction
- PC  in  WORD_W  address of fetched instruction
- flush  in  1  discard all entries (branch/jump resolved taken)
- dec_ready  in  1  pop request: decode consumes head this cycle
- instr  out  WORD_W  head instruction; 0 when empty
- pc  out  WORD_W  head npc; 0 when empty
- pcout  out  WORD_W  head PC; 0 when empty
- valid  out  1  head holds a real record
- full  out  1  count == DEPTH; fetch must hold PC
- count  out  CNT_W  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer; rd_ptr and wr_ptr are each $clog2(DEPTH) bits and wrap naturally; count is tracked separately.
- Push accepted (push_ok) when ihit && (!full || pop_ok). The record {imemload, npc, PC} is written at wr_ptr, and wr_ptr increments.
- Pop accepted (pop_ok) when dec_ready && valid. rd_ptr increments.
- count_next = count + push_ok − pop_ok. Simultaneous push and pop when full is legal; count stays DEPTH.
- ihit while full and no pop: the push is dropped; fetch is responsible for stalling on full.
- dec_ready while empty: ignored, no underflow; outputs stay 0.
- Flush has priority over everything. On a flush cycle: rd_ptr, wr_ptr and count return to 0. Any push and any pop in that same cycle are discarded.
- Head outputs: combinational read of entry rd_ptr when count != 0, otherwise all-zero (a NOP bubble, same as the legacy IF/ID flush value).
- Entry contents are not cleared on flush; only the pointers and count reset.

## Timing
- Reset: rd_ptr = wr_ptr = count = 0, valid = 0, full = 0, instr = pc = pcout = 0, and all storage entries = 0.
- Reset asserted mid-operation clears the queue asynchronously. The first push is accepted on the first rising edge after nRST deasserts.
- Push latency: a record pushed at edge N is visible on the head outputs after edge N, i.e. in the cycle following the push. Minimum latency is 1 cycle.
- Pop: head advances at the edge where pop_ok is high; the new head is visible in the next cycle.
- full and valid are registered-state derived (from count) and glitch-free relative to CLK.
- Flush at edge N: valid = 0 and outputs = 0 in cycle N+1. The push at edge N+1 is accepted normally.

## Configuration
- FETCHQ_BYPASS_EN defined: when count == 0, ihit = 1 and dec_ready = 1 with no flush, the head outputs show imemload/npc/PC combinationally with valid = 1. The record is consumed without being written, and pointers and count are unchanged. This gives zero-cycle latency in the empty case.
- FETCHQ_BYPASS_EN undefined: no bypass path. Outputs depend only on registered state, and the minimum latency is 1 cycle.

## Test plan
- Reset then idle: after nRST rises, count = 0, valid = 0, full = 0, instr = 0. dec_ready = 1 causes no change.
- Fill with DEPTH = 4 and dec_ready = 0: push instrs 0x11, 0x22, 0x33, 0x44 with PC 0x0, 0x4, 0x8, 0xC. Required: full = 1, count = 4, head instr = 0x11 with pcout = 0x0. A 5th push of 0x55 is dropped: count stays 4, and 0x55 never appears.
- Drain order with wrap: from full, pop 2 and push 0x55, 0x66. Required pop sequence: 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 with matching pc = PC+4, then valid = 0 and instr = 0.
- Simultaneous push and pop at full: count stays 4, head advances 0x11 → 0x22, and 0x55 is stored at the tail.
- Flush with push and pop: with 3 entries, assert flush, ihit (0x77) and dec_ready together. Next cycle: count = 0, valid = 0, outputs = 0, and 0x77 is absent. The following push of 0x88 appears as head one cycle later.
- Bypass (FETCHQ_BYPASS_EN): empty queue, ihit = 1 with 0x99 and dec_ready = 1. Same cycle: instr = 0x99 and valid = 1; next cycle count = 0. Without the macro: instr = 0 that cycle and 0x99 is at the head the next cycle.
